mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline. Each access runs through a 4-state FSM. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. Per-requester stall signals feed the hazard logic so that IF and MEM freeze while their access is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM encoding, streak
// counter width and the registered memory command.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_RESP  = 2'd3
    } arbState_t;

    localparam int STREAK_W = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memCmd_t;

    // Fetches are always full-word reads.
    function automatic memCmd_t fetchCmd(input logic [31:0] addr);
        memCmd_t cmd;
        cmd.we    = 1'b0;
        cmd.wmask = 4'b0000;
        cmd.addr  = addr;
        cmd.wdata = 32'h0;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the arbiter and the memory.
// slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_wmask;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_done, dm_rdata, dm_done,
        output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_done, dm_rdata, dm_done,
        input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive data grants made while fetch was waiting;
// at_limit tells the arbiter to let fetch win the next grant.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [STREAK_W-1:0] count;

    // NOTE: every flop gets an async reset value; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == STREAK_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between IF and MEM.
// Data has priority; the streak counter guarantees fetch forward progress.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    arbState_t   state;
    arbState_t   nextState;
    logic        grantData;
    logic        grantFetch;
    logic        servingData;
    logic        atLimit;
    memCmd_t     cmd;
    logic [31:0] ifRdata;
    logic [31:0] dmRdata;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (grantData & bus.if_req),
        .clr      (grantFetch | (grantData & ~bus.if_req)),
        .at_limit (atLimit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        nextState  = state;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (bus.dm_req && (!bus.if_req || !atLimit)) begin
                    grantData = 1'b1;
                    nextState = ARB_DATA;
                end else if (bus.if_req) begin
                    grantFetch = 1'b1;
                    nextState  = ARB_FETCH;
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (bus.mem_ack) nextState = ARB_RESP;
            end
            ARB_RESP: nextState = ARB_IDLE;
            default:  nextState = ARB_IDLE;
        endcase
    end

    // Outputs decode registered state only, so mem_ack never reaches them combinationally.
    always_comb begin
        bus.mem_req = (state == ARB_FETCH) || (state == ARB_DATA);
        bus.if_done = (state == ARB_RESP) && !servingData;
        bus.dm_done = (state == ARB_RESP) && servingData;
        bus.busy    = (state != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd         <= '0;
            servingData <= 1'b0;
        end else if (grantData) begin
            cmd         <= '{we: bus.dm_we, wmask: bus.dm_wmask,
                             addr: bus.dm_addr, wdata: bus.dm_wdata};
            servingData <= 1'b1;
        end else if (grantFetch) begin
            cmd         <= fetchCmd(bus.if_addr);
            servingData <= 1'b0;
        end
    end

    // Stores leave dm_rdata untouched; unsolicited acks in IDLE/RESP are dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifRdata <= '0;
            dmRdata <= '0;
        end else if (bus.mem_ack) begin
            if (state == ARB_FETCH) ifRdata <= bus.mem_rdata;
            if ((state == ARB_DATA) && !cmd.we) dmRdata <= bus.mem_rdata;
        end
    end

    assign bus.mem_we    = cmd.we;
    assign bus.mem_wmask = cmd.wmask;
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.if_rdata  = ifRdata;
    assign bus.dm_rdata  = dmRdata;

    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory
// commands and completions, a monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        bit          isData;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } expCmd_t;

    typedef struct {
        bit          isData;
        logic [31:0] rdata;
        int          doneCyc;
    } expRsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   nTotal = 0;
    int   nPass = 0;
    int   memWait = 0;
    int   strayReq = 0;

    expCmd_t cmdQ[$];
    expRsp_t rspQ[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        nTotal++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_2000: return 32'h1122_3344;
            32'h0000_3000: return 32'hCAFE_F00D;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Memory model: acks after memWait extra cycles of mem_req, or once per strayReq when idle.
    initial begin
        int waitCnt = 0;
        int straySeen = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_ack) begin
                if (waitCnt == memWait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = memWord(bus.mem_addr);
                    waitCnt       = 0;
                end else begin
                    waitCnt++;
                end
            end else if (!bus.mem_req && (strayReq != straySeen)) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
                straySeen++;
                waitCnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                waitCnt     = 0;
            end
        end
    end

    // Monitor: samples 2 time units after the falling edge, once stimulus has settled.
    initial begin
        logic    prevMemReq = 1'b0;
        expCmd_t cur;
        expRsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.mem_req && !prevMemReq) begin
                    if (cmdQ.size() == 0) begin
                        fail("unexpected_grant");
                    end else begin
                        cur = cmdQ.pop_front();
                        check("grant_addr", bus.mem_addr, cur.addr);
                        check("grant_we_wmask", {27'h0, bus.mem_we, bus.mem_wmask}, {27'h0, cur.we, cur.wmask});
                        check("grant_wdata", bus.mem_wdata, cur.wdata);
                        check("grant_stall", {31'h0, cur.isData ? bus.stall_mem : bus.stall_if}, 32'h1);
                    end
                end else if (bus.mem_req) begin
                    check("cmd_stable_addr", bus.mem_addr, cur.addr);
                    check("cmd_stable_wdata", bus.mem_wdata, cur.wdata);
                end
                if (bus.if_done || bus.dm_done) begin
                    if (rspQ.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        e = rspQ.pop_front();
                        check("done_who", {30'h0, bus.if_done, bus.dm_done}, e.isData ? 32'h1 : 32'h2);
                        check("done_rdata", e.isData ? bus.dm_rdata : bus.if_rdata, e.rdata);
                        check("done_cycle", 32'(cyc), 32'(e.doneCyc));
                        check("done_stall", {31'h0, e.isData ? bus.stall_mem : bus.stall_if}, 32'h0);
                    end
                end
            end
            prevMemReq = bus.mem_req;
        end
    end

    task automatic pushCmd(input bit isData, input logic we, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d);
        expCmd_t c;
        c.isData = isData; c.we = we; c.wmask = m; c.addr = a; c.wdata = d;
        cmdQ.push_back(c);
    endtask

    task automatic pushRsp(input bit isData, input logic [31:0] rd, input int doneCyc);
        expRsp_t r;
        r.isData = isData; r.rdata = rd; r.doneCyc = doneCyc;
        rspQ.push_back(r);
    endtask

    // Requesters are entered at a falling edge and return at the falling edge of done.
    task automatic runFetch(input logic [31:0] a);
        bit seen = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = bus.if_done;
        end
        if (!seen) fail("fetch_timeout");
        bus.if_req = 1'b0;
    endtask

    task automatic runData(input logic we, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d);
        bit seen = 1'b0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_wmask = m;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = bus.dm_done;
        end
        if (!seen) fail("data_timeout");
        bus.dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", nPass, nTotal);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [31:0] starveExp [11] = '{
            32'h4000_BFFF, 32'h4004_BFFB, 32'h4008_BFF7, 32'h400C_BFF3, 32'h0200_FDFF,
            32'h4010_BFEF, 32'h4014_BFEB, 32'h4018_BFE7, 32'h401C_BFE3, 32'h0204_FDFB,
            32'h4020_BFDF
        };
        bit starveIsData [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        logic [31:0] starveAddr [11] = '{
            32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h0200,
            32'h4010, 32'h4014, 32'h4018, 32'h401C, 32'h0204, 32'h4020
        };

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wmask = '0;
        bus.dm_addr = '0;  bus.dm_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {30'h0, bus.if_done, bus.dm_done}, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);

        // Single fetch, zero wait.
        c = cyc;
        pushCmd(0, 1'b0, 4'h0, 32'h100, 32'h0);
        pushRsp(0, 32'h0050_0093, c + 2);
        runFetch(32'h100);
        @(negedge clk);

        // Load to seed dm_rdata, then a store with two wait states.
        c = cyc;
        pushCmd(1, 1'b0, 4'hF, 32'h2000, 32'h0);
        pushRsp(1, 32'h1122_3344, c + 2);
        runData(1'b0, 4'hF, 32'h2000, 32'h0);
        @(negedge clk);
        c = cyc;
        memWait = 2;
        pushCmd(1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF);
        pushRsp(1, 32'h1122_3344, c + 4);
        runData(1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF);
        memWait = 0;
        @(negedge clk);

        // Simultaneous requests: data first, fetch next.
        c = cyc;
        pushCmd(1, 1'b0, 4'hF, 32'h3000, 32'h0);
        pushCmd(0, 1'b0, 4'h0, 32'h104, 32'h0);
        pushRsp(1, 32'hCAFE_F00D, c + 2);
        pushRsp(0, 32'h00A0_0113, c + 5);
        fork
            runData(1'b0, 4'hF, 32'h3000, 32'h0);
            runFetch(32'h104);
        join
        @(negedge clk);

        // Starvation: four data grants, one fetch, four data grants, one fetch, data.
        c = cyc;
        for (int k = 0; k < 11; k++) begin
            pushCmd(starveIsData[k], 1'b0, starveIsData[k] ? 4'hF : 4'h0, starveAddr[k], 32'h0);
            pushRsp(starveIsData[k], starveExp[k], c + 3 * k + 2);
        end
        fork
            for (int i = 0; i < 9; i++) begin
                if (i > 0) @(negedge clk);
                runData(1'b0, 4'hF, 32'h4000 + 32'(4 * i), 32'h0);
            end
            for (int j = 0; j < 2; j++) begin
                if (j > 0) @(negedge clk);
                runFetch(32'h200 + 32'(4 * j));
            end
        join
        @(negedge clk);

        // Reset during a stalled fetch, then a stray ack, then normal service.
        memWait = 5;
        pushCmd(0, 1'b0, 4'h0, 32'h300, 32'h0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        repeat (2) @(negedge clk);
        #3;
        check("pre_rst_mem_req", {31'h0, bus.mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("arst_if_done", {31'h0, bus.if_done}, 32'h0);
        check("arst_busy", {31'h0, bus.busy}, 32'h0);
        check("arst_stall_if", {31'h0, bus.stall_if}, 32'h1);
        check("arst_if_rdata", bus.if_rdata, 32'h0);
        check("arst_mem_addr", bus.mem_addr, 32'h0);
        strayReq++;
        @(negedge clk);
        bus.if_req = 1'b0;
        rst_n      = 1'b1;
        memWait    = 0;
        @(posedge clk);
        #1;
        check("stray_ack_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        check("stray_ack_done", {30'h0, bus.if_done, bus.dm_done}, 32'h0);
        check("stray_ack_rdata", bus.if_rdata, 32'h0);
        @(negedge clk);
        c = cyc;
        pushCmd(0, 1'b0, 4'h0, 32'h104, 32'h0);
        pushRsp(0, 32'h00A0_0113, c + 2);
        runFetch(32'h104);

        repeat (4) @(negedge clk);
        check("cmdq_drained", 32'(cmdQ.size()), 32'h0);
        check("rspq_drained", 32'(rspQ.size()), 32'h0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
